// File: rtl/ttpu_pkg.sv
// Shared types and default dimensions for the matrix datapath sequencer.
package ttpu_pkg;

    localparam int TTPU_N  = 16;
    localparam int TTPU_DW = 16;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_LOAD = 2'd1,
        SEQ_RUN  = 2'd2,
        SEQ_DONE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/matmul_sequencer.sv
// Sequences one N-row weight load, N feed steps and N result vectors; start-to-done is 2N+LAT+1 cycles.
// out_ready low during RUN freezes the run counter and masks feed/result strobes; LOAD ignores it.
module matmul_sequencer
    import ttpu_pkg::*;
#(
    parameter int N   = TTPU_N,
    parameter int LAT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 w_load,
    output logic [$clog2(N)-1:0] w_row,
    output logic                 feed_en,
    output logic [$clog2(N)-1:0] feed_step,
    output logic                 res_valid,
    output logic [$clog2(N)-1:0] res_idx
);

    localparam int AW = $clog2(N);
    localparam int CW = $clog2(LAT + N + 1);

    localparam logic [AW-1:0] ROW_LAST = AW'(N - 1);
    localparam logic [CW-1:0] N_T      = CW'(N);
    localparam logic [CW-1:0] LAT_T    = CW'(LAT);
    localparam logic [CW-1:0] RES_END  = CW'(LAT + N);
    localparam logic [CW-1:0] T_LAST   = CW'(LAT + N - 1);

    seq_state_t    state_q, state_d;
    logic [AW-1:0] row_q, row_d;
    logic [CW-1:0] t_q, t_d;

    logic in_feed;
    logic in_res;

    // Feed and result windows are both decoded from the single run counter.
    assign in_feed = (t_q < N_T);
    assign in_res  = (t_q >= LAT_T) && (t_q < RES_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEQ_IDLE;
            row_q   <= '0;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            t_q     <= t_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        t_d       = t_q;
        busy      = 1'b0;
        done      = 1'b0;
        w_load    = 1'b0;
        w_row     = '0;
        feed_en   = 1'b0;
        feed_step = '0;
        res_valid = 1'b0;
        res_idx   = '0;

        unique case (state_q)
            SEQ_IDLE: begin
                if (start) begin
                    state_d = SEQ_LOAD;
                    row_d   = '0;
                end
            end

            SEQ_LOAD: begin
                busy   = 1'b1;
                w_load = 1'b1;
                w_row  = row_q;
                if (row_q == ROW_LAST) begin
                    state_d = SEQ_RUN;
                    row_d   = '0;
                    t_d     = '0;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end

            SEQ_RUN: begin
                busy      = 1'b1;
                feed_en   = in_feed && out_ready;
                res_valid = in_res && out_ready;
                // Indices track the held counter, so they stay put while stalled.
                if (in_feed) begin
                    feed_step = AW'(t_q);
                end
                if (in_res) begin
                    res_idx = AW'(t_q - LAT_T);
                end
                if (out_ready) begin
                    if (t_q == T_LAST) begin
                        state_d = SEQ_DONE;
                        t_d     = '0;
                    end else begin
                        t_d = t_q + 1'b1;
                    end
                end
            end

            SEQ_DONE: begin
                done    = 1'b1;
                state_d = SEQ_IDLE;
            end

            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench: a cycle model pushes expected strobe/index events, a negedge monitor pops and compares.
module tb_matmul_sequencer;
    import ttpu_pkg::*;

    localparam int N    = 16;
    localparam int LAT  = 16;
    localparam int LAT2 = 4;

    typedef struct {
        int cyc;
        int idx;
    } ev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic out_ready = 1'b1;
    logic start2 = 1'b0;
    logic out_ready2 = 1'b1;

    logic       busy, done, w_load, feed_en, res_valid;
    logic [3:0] w_row, feed_step, res_idx;
    logic       busy2, done2, w_load2, feed_en2, res_valid2;
    logic [3:0] w_row2, feed_step2, res_idx2;

    int checks = 0;
    int errors = 0;
    int cur = 0;
    bit mon_en = 1'b0;

    int st_lo = -1, st_hi = -2;
    int sl_lo = -1, sl_hi = -2;
    int st2 = -1;

    ev_t q_w[$];
    ev_t q_f[$];
    ev_t q_r[$];
    int  q_d[$];
    bit  exp_busy[int];
    int  exp_hold[int];

    int ov_cnt = 0, ov_first = -1, ov_last = -1, done2_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cur <= cur + 1;

    matmul_sequencer #(.N(N), .LAT(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .out_ready(out_ready),
        .busy(busy), .done(done), .w_load(w_load), .w_row(w_row),
        .feed_en(feed_en), .feed_step(feed_step),
        .res_valid(res_valid), .res_idx(res_idx)
    );

    matmul_sequencer #(.N(N), .LAT(LAT2)) u_ovl (
        .clk(clk), .rst_n(rst_n), .start(start2), .out_ready(out_ready2),
        .busy(busy2), .done(done2), .w_load(w_load2), .w_row(w_row2),
        .feed_en(feed_en2), .feed_step(feed_step2),
        .res_valid(res_valid2), .res_idx(res_idx2)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cur, obs, exp);
        end
    endtask

    // Cycle model of one pass whose start is driven during cycle s; returns the done cycle.
    task automatic push_pass(input int s, input int lo, input int hi, output int d_cyc);
        int c;
        int t;
        c = s + 1;
        for (int r = 0; r < N; r++) begin
            q_w.push_back('{c, r});
            exp_busy[c] = 1'b1;
            c++;
        end
        t = 0;
        while (1) begin
            exp_busy[c] = 1'b1;
            if (c >= lo && c <= hi) begin
                if (t < N) exp_hold[c] = t;
                c++;
                continue;
            end
            if (t < N) q_f.push_back('{c, t});
            if (t >= LAT && t < LAT + N) q_r.push_back('{c, t - LAT});
            if (t == LAT + N - 1) begin
                c++;
                break;
            end
            t++;
            c++;
        end
        q_d.push_back(c);
        d_cyc = c;
    endtask

    task automatic step_to(input int c_end);
        while (cur < c_end) begin
            @(posedge clk);
            #1;
            start      = (cur >= st_lo && cur <= st_hi);
            out_ready  = !(cur >= sl_lo && cur <= sl_hi);
            start2     = (cur == st2);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_wload"}, int'(w_load), 0);
        chk({tag, "_wrow"}, int'(w_row), 0);
        chk({tag, "_feed"}, int'(feed_en), 0);
        chk({tag, "_fstep"}, int'(feed_step), 0);
        chk({tag, "_rvld"}, int'(res_valid), 0);
        chk({tag, "_ridx"}, int'(res_idx), 0);
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (mon_en) begin
            if (w_load) begin
                if (q_w.size() == 0) chk("w_extra", int'(w_load), 0);
                else begin
                    e = q_w.pop_front();
                    chk("w_cyc", cur, e.cyc);
                    chk("w_row", int'(w_row), e.idx);
                end
            end else if (q_w.size() > 0 && q_w[0].cyc <= cur) begin
                chk("w_miss", int'(w_load), 1);
                void'(q_w.pop_front());
            end

            if (feed_en) begin
                if (q_f.size() == 0) chk("f_extra", int'(feed_en), 0);
                else begin
                    e = q_f.pop_front();
                    chk("f_cyc", cur, e.cyc);
                    chk("f_step", int'(feed_step), e.idx);
                end
            end else if (q_f.size() > 0 && q_f[0].cyc <= cur) begin
                chk("f_miss", int'(feed_en), 1);
                void'(q_f.pop_front());
            end

            if (res_valid) begin
                if (q_r.size() == 0) chk("r_extra", int'(res_valid), 0);
                else begin
                    e = q_r.pop_front();
                    chk("r_cyc", cur, e.cyc);
                    chk("r_idx", int'(res_idx), e.idx);
                end
            end else if (q_r.size() > 0 && q_r[0].cyc <= cur) begin
                chk("r_miss", int'(res_valid), 1);
                void'(q_r.pop_front());
            end

            if (done) begin
                if (q_d.size() == 0) chk("d_extra", int'(done), 0);
                else chk("d_cyc", cur, q_d.pop_front());
            end else if (q_d.size() > 0 && q_d[0] <= cur) begin
                chk("d_miss", int'(done), 1);
                void'(q_d.pop_front());
            end

            chk("busy", int'(busy), int'(exp_busy.exists(cur)));

            if (exp_hold.exists(cur)) begin
                chk("stall_feed", int'(feed_en), 0);
                chk("stall_step", int'(feed_step), exp_hold[cur]);
            end

            if (feed_en2 && res_valid2) begin
                ov_cnt++;
                if (ov_first < 0) ov_first = cur;
                ov_last = cur;
            end
            if (done2) begin
                done2_cnt++;
                chk("ovl_done_cyc", cur, st2 + 2 * N + LAT2 + 1);
            end
        end
    end

    initial begin
        int s;
        int d1;
        int d2;

        // Reset values
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero_outputs("rst");
        chk("rst_state", int'(u_dut.state_q), int'(SEQ_IDLE));
        chk("rst_ovl_busy", int'(busy2), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        chk("post_rst_state", int'(u_dut.state_q), int'(SEQ_IDLE));

        // Nominal pass
        s = cur + 3;
        st_lo = s; st_hi = s;
        push_pass(s, 1, 0, d1);
        chk("nom_latency", d1 - s, 2 * N + LAT + 1);
        step_to(d1 + 4);

        // Stalled pass: out_ready low for three cycles while feeding step 3
        s = cur + 3;
        st_lo = s; st_hi = s;
        sl_lo = s + 20; sl_hi = s + 22;
        push_pass(s, sl_lo, sl_hi, d1);
        step_to(d1 + 4);
        sl_lo = -1; sl_hi = -2;

        // start held through the whole pass: one pass, then a new one right after IDLE
        s = cur + 3;
        st_lo = s;
        push_pass(s, 1, 0, d1);
        st_hi = d1 + 1;
        push_pass(d1 + 1, 1, 0, d2);
        step_to(d2 + 4);

        // Reset asserted mid-RUN at t=7
        s = cur + 3;
        st_lo = s; st_hi = s;
        push_pass(s, 1, 0, d1);
        step_to(s + N + 8);
        chk("pre_rst_feed", int'(feed_en), 1);
        chk("pre_rst_step", int'(feed_step), 7);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk_zero_outputs("mid_rst");
        q_w.delete(); q_f.delete(); q_r.delete(); q_d.delete();
        exp_busy.delete(); exp_hold.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        step_to(d1 + 4);
        s = cur + 3;
        st_lo = s; st_hi = s;
        push_pass(s, 1, 0, d1);
        step_to(d1 + 4);

        // Overlapping windows on the LAT=4 instance
        s = cur + 3;
        st2 = s;
        step_to(s + 2 * N + LAT2 + 6);
        chk("ovl_count", ov_cnt, N - LAT2);
        chk("ovl_first", ov_first, s + N + 1 + LAT2);
        chk("ovl_last", ov_last, s + 2 * N);
        chk("ovl_dones", done2_cnt, 1);

        chk("queues_left", q_w.size() + q_f.size() + q_r.size() + q_d.size(), 0);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
